// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache read-path controller and the datapath that
// instantiates the 3:1 read-data mux.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    REFILL  = 2'd2,
    WR_THRU = 2'd3
  } state_t;

  localparam logic [1:0] SEL_CACHE  = 2'b00;
  localparam logic [1:0] SEL_REFILL = 2'b01;
  localparam logic [1:0] SEL_ZERO   = 2'b10;

  // Slot indices of the performance counters inside the controller
  localparam int PERF_HIT  = 0;
  localparam int PERF_MISS = 1;
  localparam int PERF_N    = 2;

endpackage

// File: rtl/dcache_ctrl_sat_counter.sv
// Saturating up-counter for the cache performance statistics; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache read-path sequencer: picks the read-data source, stalls for read-miss
// refills and write-through stores, and counts load hits/misses.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              hit,
  output logic              stall,
  output logic [1:0]        data_sel,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic              refill_we,
  output logic              cache_we,
  output logic [PERF_W-1:0] hit_cnt,
  output logic [PERF_W-1:0] miss_cnt
);

  localparam int CNT_RAW = $clog2(MEM_LATENCY + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  // The IDLE detect cycle already counts as one cycle of the memory wait
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              hit_q_reg, hit_q_next;
  logic [PERF_N-1:0] perf_inc;
  logic [PERF_W-1:0] perf_cnt [PERF_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hit_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hit_q_reg <= hit_q_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hit_q_next = hit_q_reg;
    stall      = 1'b0;
    data_sel   = SEL_ZERO;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    refill_we  = 1'b0;
    cache_we   = 1'b0;
    perf_inc   = '0;

    case (state_reg)
      IDLE: begin
        if (mem_write) begin
          stall      = 1'b1;
          mem_wr_req = 1'b1;
          hit_q_next = hit;
          cnt_next   = CNT_LOAD;
          state_next = WR_THRU;
        end else if (mem_read) begin
          if (hit) begin
            data_sel           = SEL_CACHE;
            perf_inc[PERF_HIT] = 1'b1;
          end else begin
            stall               = 1'b1;
            mem_rd_req          = 1'b1;
            perf_inc[PERF_MISS] = 1'b1;
            cnt_next            = CNT_LOAD;
            state_next          = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall      = 1'b1;
        mem_rd_req = 1'b1;
        if (cnt_reg == '0) begin
          state_next = REFILL;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      REFILL: begin
        refill_we  = 1'b1;
        data_sel   = SEL_REFILL;
        state_next = IDLE;
      end
      WR_THRU: begin
        mem_wr_req = 1'b1;
        if (cnt_reg != '0) begin
          stall    = 1'b1;
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          // No-write-allocate: only a store that hit updates the array
          cache_we   = hit_q_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Reset must silence the Mealy outputs at once, even with live IDLE inputs
    if (rst) begin
      stall      = 1'b0;
      data_sel   = SEL_ZERO;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      refill_we  = 1'b0;
      cache_we   = 1'b0;
      perf_inc   = '0;
    end
  end

  for (genvar gi = 0; gi < PERF_N; gi++) begin : g_perf
    sat_counter #(.W(PERF_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (perf_inc[gi]),
      .count (perf_cnt[gi])
    );
  end

  assign hit_cnt  = perf_cnt[PERF_HIT];
  assign miss_cnt = perf_cnt[PERF_MISS];

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Sequencing controller for the data-cache read path of the RISC-V core. It decides whether a load is served from the cache array, from the refill data returning from main memory, or gets zero. It drives the 2-bit select of the 32-bit 3:1 read-data mux accordingly.
It also stalls the pipeline during read-miss refills and write-through stores, times main-memory accesses with an internal latency counter, and keeps hit/miss performance counters.
Policy: direct-mapped, write-through, no-write-allocate, whole-block refill over a wide memory bus.

Parameters:
MEM_LATENCY, 4, main-memory access time in cycles; legal range 1..255
PERF_W, 16, width of the saturating hit/miss counters

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
mem_read  input  1  load in MEM stage
mem_write  input  1  store in MEM stage
hit  input  1  tag-compare result (valid & tag match) from the cache tag array
stall  output  1  freeze the pipeline (PC, IF/ID, ID/EX, EX/MEM)
data_sel  output  2  read-data mux select: 2'b00 cache word, 2'b01 refill word, 2'b10 zero
mem_rd_req  output  1  main-memory block read request
mem_wr_req  output  1  main-memory word write request
refill_we  output  1  write refilled block into cache data/tag/valid arrays
cache_we  output  1  write store word into cache (write hit only)
hit_cnt  output  PERF_W  load hits, saturating
miss_cnt  output  PERF_W  load misses, saturating

Behaviour:
- Reset (async, immediate):
  - state=IDLE, cnt=0, hit_q=0.
  - Outputs: stall=0, data_sel=2'b10, all request/enable outputs 0, hit_cnt=0, miss_cnt=0.
  - Reset mid-access aborts the access; mem_rd_req/mem_wr_req drop in the same cycle, no cache write occurs.
- FSM states: IDLE, RD_MISS, REFILL, WR_THRU. Registered state; outputs are Mealy, decoded from state plus IDLE-cycle inputs.
- Inputs are sampled only in IDLE. Changes to mem_read/mem_write/hit in other states are ignored.
- IDLE:
  - mem_write=1 (has priority over mem_read if both are high): stall=1, mem_wr_req=1, hit_q<=hit, cnt<=MEM_LATENCY-1; next state WR_THRU, or IDLE with release if MEM_LATENCY=1 (see WR_THRU).
  - mem_read=1, hit=1: stall=0, data_sel=00, hit_cnt+1; stay in IDLE. Back-to-back hits are served every cycle.
  - mem_read=1, hit=0: stall=1, mem_rd_req=1, data_sel=10, miss_cnt+1, cnt<=MEM_LATENCY-1; next state RD_MISS.
  - neither asserted: data_sel=10, stall=0.
- RD_MISS: stall=1, mem_rd_req=1, data_sel=10. cnt decrements each cycle; when cnt==0, next state REFILL.
- REFILL (one cycle): refill_we=1, data_sel=01 (refill word bypassed to WB), stall=0, mem_rd_req=0; next state IDLE.
  - The load therefore sees stall high for exactly MEM_LATENCY+1 cycles (the IDLE detect cycle plus MEM_LATENCY RD_MISS cycles). Data appears on the cycle stall falls.
  - The replayed load is not re-counted: the pipeline advances out of MEM on the REFILL cycle.
- WR_THRU: mem_wr_req=1, data_sel=10.
  - cnt>0: stall=1, cnt decrements.
  - cnt==0: stall=0, cache_we=hit_q; next state IDLE.
  - Store stall is exactly MEM_LATENCY cycles total (IDLE detect cycle included); mem_wr_req is high for MEM_LATENCY+1 cycles.
  - A write miss never writes the cache (no-write-allocate).
- Counter width: CNT_W = $clog2(MEM_LATENCY+1), minimum 1. MEM_LATENCY=1 means the IDLE detect cycle is the whole wait:
  - RD_MISS lasts 1 cycle.
  - For WR_THRU, cnt is loaded with 0 and the next cycle releases.
- Perf counters saturate at all-ones; no wrap. They are counted only on the IDLE detect cycle.
- Illegal state encoding → IDLE.

Decomposition:
- Shared package dcache_pkg: state encoding (IDLE=2'd0, RD_MISS=2'd1, REFILL=2'd2, WR_THRU=2'd3) and mux-select constants (SEL_CACHE=2'b00, SEL_REFILL=2'b01, SEL_ZERO=2'b10). These constants are reused by the datapath top level that instantiates the 3:1 mux.
- One natural sub-module, sat_counter (parameter W, inputs inc/clk/rst, output count), instantiated twice for hit_cnt and miss_cnt. The FSM and latency counter stay in dcache_ctrl.

Test Plan:
1. Reset: assert rst mid-RD_MISS at cycle 2 → stall, mem_rd_req drop same cycle, data_sel=10, counters 0; after release, idle with no stall.
2. Read-hit stream: mem_read=1, hit=1 for 5 cycles → stall=0, data_sel=00 each cycle, hit_cnt=5, miss_cnt=0.
3. Read miss, MEM_LATENCY=4: mem_read=1, hit=0 at cycle 0.
   - Cycles 0–4: stall=1, mem_rd_req=1.
   - Cycle 5: refill_we=1, data_sel=01, stall=0.
   - Result: miss_cnt=1.
4. Write hit then write miss, MEM_LATENCY=4:
   - Write hit: stall=1 cycles 0–3; cycle 4 cache_we=1, stall=0, mem_wr_req high cycles 0–4.
   - Write miss, same timing: cache_we stays 0.
5. mem_read=1 and mem_write=1 together with hit=0 → treated as store: mem_wr_req=1, mem_rd_req=0, miss_cnt unchanged. MEM_LATENCY=1 build: read miss stalls 2 cycles, store stalls 1 cycle.
6. Saturation, PERF_W=4: 20 read hits → hit_cnt=15 and holds; a further miss → miss_cnt=1.
